// File: rtl/periph_pkg.sv
// Shared constants for the MEM-stage peripheral window: register offsets,
// TCON bit positions and the default base address.
package periph_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Byte offsets within the 32-byte decode window
    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_DISP    = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    localparam logic [2:0] NUM_REGS = 3'd6;

    // Word slots 6 and 7 of the window are holes and never hit
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base);
        return (a[31:5] == base[31:5]) && (a[4:2] < NUM_REGS);
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Reloadable interval timer: prescaler, TL/TH counters and TCON with
// sticky overflow status and a registered interrupt output.
module interval_timer
    import periph_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wr_data,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc;
    logic        tick;
    logic        overflow;
    logic        is_set;
    logic [2:0]  tcon_next;

    assign tick     = tcon[TCON_EN] && (presc == DIV_LAST);
    // A software write to TL on a tick edge swallows the tick, overflow included
    assign overflow = tick && (tl == 32'hFFFF_FFFF) && !tl_we;
    assign is_set   = overflow && tcon[TCON_IE];

    // Overflow status is ORed in after any software write so it is never lost
    always_comb begin
        tcon_next = tcon;
        if (tcon_we) begin
            tcon_next = wr_data[2:0];
        end
        tcon_next[TCON_IS] = tcon_next[TCON_IS] | is_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tcon[TCON_EN]) begin
            presc <= (presc == DIV_LAST) ? 16'd0 : presc + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tl <= '0;
        end else if (tl_we) begin
            tl <= wr_data;
        end else if (tick) begin
            tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th <= '0;
        end else if (th_we) begin
            th <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon <= '0;
            irq  <= 1'b0;
        end else begin
            tcon <= tcon_next;
            irq  <= tcon_next[TCON_IE] & tcon_next[TCON_IS];
        end
    end

endmodule

// File: rtl/mmio_periph.sv
// MEM-stage peripheral block: address decode, zero-latency read mux, LED and
// display registers, free-running SYSTICK and the interval timer.
module mmio_periph
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        irq,
    output logic [15:0] led,
    output logic [15:0] disp_value
);

    logic        hit;
    logic        wr_hit;
    logic [4:0]  off;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic        unused_byte_lane;

    // Byte lane bits are don't-care: any byte address inside a word selects it
    assign unused_byte_lane = ^addr[1:0];

    assign off    = {addr[4:2], 2'b00};
    assign hit    = in_window(addr, BASE_ADDR);
    assign rd_hit = hit & mem_read;
    assign wr_hit = hit & mem_write;

    interval_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (wr_hit && (off == OFF_TH)),
        .tl_we   (wr_hit && (off == OFF_TL)),
        .tcon_we (wr_hit && (off == OFF_TCON)),
        .wr_data (wr_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led        <= '0;
            disp_value <= '0;
        end else if (wr_hit) begin
            if (off == OFF_LED) begin
                led <= wr_data[15:0];
            end
            if (off == OFF_DISP) begin
                disp_value <= wr_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            case (off)
                OFF_TH:      rd_data = th;
                OFF_TL:      rd_data = tl;
                OFF_TCON:    rd_data = {29'd0, tcon};
                OFF_LED:     rd_data = {16'd0, led};
                OFF_DISP:    rd_data = {16'd0, disp_value};
                OFF_SYSTICK: rd_data = systick;
                default:     rd_data = '0;
            endcase
        end
    end

endmodule

// File: doc/mmio_periph.md
Name: mmio_periph

Overview:
- Memory-mapped peripheral block on the MEM stage of the 5-stage pipeline.
- Sits beside the data memory and decodes the same ALU-result address, store data and read/write strobes.
- Provides a reloadable interval timer with interrupt, a free-running systick counter, an LED register and a 16-bit display-value register that feeds the seven-segment scanner.
- A read hit from this block overrides the data-memory read data in the MEM stage.

Parameters:
- BASE_ADDR, 32'h40000000, base of the 6-word peripheral window (word-aligned, 24 bytes).
- TICK_DIV, 1, timer prescale: TL advances once every TICK_DIV enabled cycles (valid range 1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- addr  in  32  MEM-stage byte address (ALU result)
- wr_data  in  32  MEM-stage store data
- mem_read  in  1  load strobe
- mem_write  in  1  store strobe
- rd_data  out  32  read data, combinational
- rd_hit  out  1  address in window and mem_read=1
- irq  out  1  timer interrupt request
- led  out  16  LED register
- disp_value  out  16  value for the display scanner

Behaviour:
- Register map, offset from BASE_ADDR:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bit0 enable, bit1 irq_en, bit2 irq_status. All bits R/W; writing 0 to bit2 clears it; bits 31:3 read 0.
  - 0x0C LED: bits 15:0 R/W, upper bits read 0.
  - 0x10 DISP: bits 15:0 R/W, upper bits read 0.
  - 0x14 SYSTICK: read-only; writes are ignored.
- Decode: hit when addr[31:5] matches BASE_ADDR[31:5], addr[4:2] is in 0..5 and addr[1:0] is ignored. Offsets 0x18–0x1C return 0 with rd_hit=0.
- Reads: combinational and zero-latency.
  - rd_data = selected register when rd_hit=1, else 0.
  - A read returns the pre-edge value, even if a write or timer event lands on the same edge.
- Writes: take effect at the posedge where mem_write=1 and the address hits.
- Reset (async): TH, TL, TCON, LED, DISP and SYSTICK all go to 0; the prescaler counter goes to 0; irq=0, led=0, disp_value=0.
  - Reset mid-count abandons the count with no irq.
- SYSTICK: increments every cycle after reset; wraps 32'hFFFFFFFF → 0.
- Prescaler: runs only while TCON.enable=1.
  - Counts 0..TICK_DIV-1, then emits a tick and returns to 0.
  - Clearing enable holds both the prescaler and TL.
- On a tick:
  - If TL == 32'hFFFFFFFF: TL <= TH (overflow), and TCON.irq_status <= 1 if irq_en=1.
  - Otherwise TL <= TL + 1.
- irq = TCON.irq_en & TCON.irq_status, registered-source, glitch-free.
- Simultaneous events:
  - CPU write to TL on a tick edge: the write wins and the tick is lost.
  - CPU write to TCON on an overflow edge: new enable/irq_en come from the write; irq_status = written bit2 OR overflow-set.
  - An overflow is never lost to a software clear in the same cycle.
  - CPU write to TH on an overflow edge: the reload uses the old TH.
- mem_read and mem_write both high at a hit address: the read returns the old value and the write commits.
- disp_value and led are direct register outputs with no extra latency.

Decomposition:
- Shared package (periph_pkg):
  - Offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_DISP, OFF_SYSTICK.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IS=2.
  - Default BASE_ADDR.
- One natural sub-module, interval_timer:
  - Contains the prescaler, TL/TH/TCON update and the overflow/irq_status logic.
  - Takes decoded write-enables and write data; presents TH, TL and TCON.
- mmio_periph keeps decode, read mux, LED/DISP registers and SYSTICK.

Test Plan:
- Reset then read 0x40000014 after 10 cycles → rd_data=10, rd_hit=1. Read 0x40000018 → rd_hit=0, rd_data=0.
- Store 0x0000BEEF to 0x4000000C and 0x00001234 to 0x40000010 → led=16'hBEEF and disp_value=16'h1234 the cycle after the store edge. Readback of 0x4000000C = 32'h0000BEEF.
- TICK_DIV=1, TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 → TL reads FFFFFFFF, then FFFFFFFC one cycle later. TCON reads 7 and irq=1 from that edge onward.
- irq pending; write TCON=3 on the same edge as a second overflow → irq_status stays 1 and irq stays high. Write TCON=3 on a non-overflow edge → irq=0 next cycle.
- TICK_DIV=4, TL=0, enable → TL=1 after 4 cycles and TL=2 after 8. Clearing enable at cycle 6 holds TL=1 indefinitely.
- Assert reset for 1 cycle mid-count with TL=0x55 → all outputs and registers 0 immediately (asynchronous), irq=0, and SYSTICK restarts from 0.
